// File: rtl/multi_alarm_ctrl.sv
// Clock/alarm setting controller: mode, edit, commit and arm keys.
// One display/edit FSM shared by the clock and every alarm channel.
module multi_alarm_ctrl #(
  parameter int                  NUM_ALARM   = 2,
  parameter int                  DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] DIGIT_MAX   = 16'h2959,
  parameter int                  TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_in_m,
  input  logic                  key_in_e,
  input  logic                  key_in_p,
  input  logic                  key_in_n,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [1:0]            sel,
  output logic                  mode_edit,
  output logic                  en_clk,
  output logic [1:0]            edit_pos,
  output logic [4*DIGITS-1:0]   data_out,
  output logic                  clock_load,
  output logic [NUM_ALARM-1:0]  alarm_load,
  output logic [NUM_ALARM-1:0]  alarm_en
);

  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(TIMEOUT_CYC+1);

  typedef enum logic {DISP, EDIT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           pos_q, pos_d;
  logic [W-1:0]         data_q, data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 cl_q, cl_d;
  logic [NUM_ALARM-1:0] al_q, al_d;
  logic [NUM_ALARM-1:0] aen_q, aen_d;
  logic                 en_clk_q, en_clk_d;

  logic         k_m, k_e, k_p, k_n, any_key;
  logic [W-1:0] clamp_buf, inc_buf, dec_buf;

  // Strict priority m > e > p > n
  assign k_m     = key_in_m;
  assign k_e     = key_in_e & ~key_in_m;
  assign k_p     = key_in_p & ~key_in_m & ~key_in_e;
  assign k_n     = key_in_n & ~key_in_m & ~key_in_e & ~key_in_p;
  assign any_key = key_in_m | key_in_e | key_in_p | key_in_n;

  always_comb begin
    logic [3:0] d_lim;
    logic [3:0] d_in;
    logic [3:0] d_cur;
    clamp_buf = '0;
    inc_buf   = data_q;
    dec_buf   = data_q;
    for (int i = 0; i < DIGITS; i++) begin
      d_lim = DIGIT_MAX[4*i +: 4];
      d_in  = data_in[4*i +: 4];
      d_cur = data_q[4*i +: 4];
      clamp_buf[4*i +: 4] = (d_in > d_lim) ? d_lim : d_in;
      if (pos_q == 2'(i)) begin
        inc_buf[4*i +: 4] = (d_cur >= d_lim) ? 4'd0 : d_cur + 4'd1;
        dec_buf[4*i +: 4] = (d_cur == 4'd0) ? d_lim : d_cur - 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pos_d   = pos_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    aen_d   = aen_q;
    cl_d    = 1'b0;
    al_d    = '0;
    unique case (state_q)
      DISP: begin
        if (k_m) begin
          sel_d = (int'(sel_q) >= NUM_ALARM) ? 2'd0 : sel_q + 2'd1;
        end else if (k_e) begin
          state_d = EDIT;
          data_d  = clamp_buf;
          pos_d   = 2'(DIGITS-1);
          cnt_d   = '0;
        end else if (k_p) begin
          for (int i = 0; i < NUM_ALARM; i++)
            if (sel_q == 2'(i+1)) aen_d[i] = ~aen_q[i];
        end
      end
      EDIT: begin
        if (any_key) cnt_d = '0;
        if (k_m) begin
          state_d = DISP;
        end else if (k_e) begin
          if (pos_q != 2'd0) begin
            pos_d = pos_q - 2'd1;
          end else begin
            state_d = DISP;
            cl_d    = (sel_q == 2'd0);
            for (int i = 0; i < NUM_ALARM; i++)
              al_d[i] = (sel_q == 2'(i+1));
          end
        end else if (k_p) begin
          data_d = inc_buf;
        end else if (k_n) begin
          data_d = dec_buf;
        end else if (cnt_q >= CW'(TIMEOUT_CYC)) begin
          state_d = DISP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = DISP;
    endcase
    en_clk_d = !((state_d == EDIT) && (sel_d == 2'd0));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= DISP;
      sel_q    <= 2'd0;
      pos_q    <= 2'd0;
      data_q   <= '0;
      cnt_q    <= '0;
      cl_q     <= 1'b0;
      al_q     <= '0;
      aen_q    <= '0;
      en_clk_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pos_q    <= pos_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      cl_q     <= cl_d;
      al_q     <= al_d;
      aen_q    <= aen_d;
      en_clk_q <= en_clk_d;
    end
  end

  assign sel        = sel_q;
  assign mode_edit  = (state_q == EDIT);
  assign en_clk     = en_clk_q;
  assign edit_pos   = pos_q;
  assign data_out   = data_q;
  assign clock_load = cl_q;
  assign alarm_load = al_q;
  assign alarm_en   = aen_q;

endmodule
